regfile_wb_arbiter: RTL and testbench

- Owns the single register-file write port (we/a3/wd) and shares it between the in-order pipeline writeback and a long-latency multiply/divide unit (MDU).
- Pipeline writeback always wins the port. MDU results wait in a small FIFO until a free port cycle.
- Keeps a pending-destination scoreboard so decode stalls on RAW/WAW hazards against in-flight MDU results.
- Sits between the WB stage, the MDU and RegMem; drives RegMem write inputs directly.

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_wb_result_fifo.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 89 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Latency: none (types and constants only).
// Backpressure: none.
package regfile_wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int NREG = 32;

  typedef logic [RA_W-1:0] ra_t;

  // One buffered MDU result: destination register plus data.
  typedef struct packed {
    ra_t             rd;
    logic [XLEN-1:0] wd;
  } fifo_ent_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of WB, MDU, decode and RegMem signals around the writeback arbiter.
// Latency: none (wiring only).
// Backpressure: mdu_ready to the MDU, stall to decode.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic            wb_we;
  ra_t             wb_rd;
  logic [XLEN-1:0] wb_wd;
  logic            iss_mdu;
  ra_t             iss_rd;
  logic            mdu_valid;
  ra_t             mdu_rd;
  logic [XLEN-1:0] mdu_wd;
  logic            mdu_ready;
  ra_t             dec_rs1;
  ra_t             dec_rs2;
  ra_t             dec_rd;
  logic            stall;
  logic            rf_we;
  ra_t             rf_a3;
  logic [XLEN-1:0] rf_wd;

  // Arbiter side.
  modport slave (
    input  wb_we, wb_rd, wb_wd, iss_mdu, iss_rd,
    input  mdu_valid, mdu_rd, mdu_wd, dec_rs1, dec_rs2, dec_rd,
    output mdu_ready, stall, rf_we, rf_a3, rf_wd
  );

  // Pipeline / MDU / RegMem side.
  modport master (
    output wb_we, wb_rd, wb_wd, iss_mdu, iss_rd,
    output mdu_valid, mdu_rd, mdu_wd, dec_rs1, dec_rs2, dec_rd,
    input  mdu_ready, stall, rf_we, rf_a3, rf_wd
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_result_fifo.sv
// Small circular FIFO holding MDU results until the RegMem port is free.
// Latency: head visible the cycle after the push edge.
// Backpressure: push ignored while full; pop ignored while empty.
module wb_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  fifo_ent_t push_ent,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output fifo_ent_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_ent_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ent;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegMem write port between pipeline WB (priority) and buffered MDU results; tracks pending MDU destinations. Optional macro: RF_BYPASS_EN.
// Latency: MDU result reaches RegMem >=1 cycle after arrival (0 cycles via bypass when enabled and the port is idle).
// Backpressure: mdu_ready = !full from registered state; stall to decode on pending rs1/rs2/rd.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);

  logic            port_busy;
  logic            bypass;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  fifo_ent_t       push_ent;
  fifo_ent_t       head;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_set;
  logic [NREG-1:0] pend_clr;

  // A writeback to x0 does not occupy the port.
  assign port_busy = bus.wb_we && (bus.wb_rd != '0);

`ifdef RF_BYPASS_EN
  assign bypass = !port_busy && fifo_empty && bus.mdu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push     = bus.mdu_valid && !fifo_full && !bypass;
  assign fifo_pop      = !port_busy && !fifo_empty;
  assign bus.mdu_ready = !fifo_full;
  assign push_ent      = '{rd: bus.mdu_rd, wd: bus.mdu_wd};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_ent (push_ent),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  // Port mux: pipeline first, then FIFO head, then (optionally) the live MDU result.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = '0;
    bus.rf_wd = '0;
    if (port_busy) begin
      bus.rf_we = 1'b1;
      bus.rf_a3 = bus.wb_rd;
      bus.rf_wd = bus.wb_wd;
    end else if (!fifo_empty) begin
      bus.rf_we = (head.rd != '0);
      bus.rf_a3 = head.rd;
      bus.rf_wd = head.wd;
    end else if (bypass) begin
      bus.rf_we = (bus.mdu_rd != '0);
      bus.rf_a3 = bus.mdu_rd;
      bus.rf_wd = bus.mdu_wd;
    end
  end

  // Scoreboard set/clear masks for this cycle.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (bus.iss_mdu) pend_set[bus.iss_rd] = 1'b1;
    if (fifo_pop)    pend_clr[head.rd]    = 1'b1;
    if (bypass)      pend_clr[bus.mdu_rd] = 1'b1;
  end

  // Pending-destination scoreboard: set wins over clear, x0 never pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= ((pend & ~pend_clr) | pend_set) & {{(NREG-1){1'b1}}, 1'b0};
  end

  // RAW on rs1/rs2 and WAW on rd against in-flight MDU results.
  assign bus.stall = pend[bus.dec_rs1] | pend[bus.dec_rs2] | pend[bus.dec_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of buffered results and a pending-register set.
  fifo_ent_t   q[$];
  logic [31:0] pend_m;
  int          writes[$];
  logic        m_pop, m_byp, m_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.wb_we = 0; bus.wb_rd = 0; bus.wb_wd = 0;
    bus.iss_mdu = 0; bus.iss_rd = 0;
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_wd = 0;
    bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0;
  endtask

  // Compare combinational outputs against the model for the current inputs.
  task automatic settle_check();
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        chk_wd;
    #1;
    m_ready = (q.size() < DEPTH);
    m_pop = 0; m_byp = 0; chk_wd = 1;
    e_we = 0; e_a3 = 0; e_wd = 0;
    if (bus.wb_we && bus.wb_rd != 0) begin
      e_we = 1; e_a3 = bus.wb_rd; e_wd = bus.wb_wd;
    end else if (q.size() > 0) begin
      e_we = (q[0].rd != 0); e_a3 = q[0].rd; e_wd = q[0].wd; m_pop = 1;
      chk_wd = e_we;
    end
`ifdef RF_BYPASS_EN
    else if (bus.mdu_valid) begin
      e_we = (bus.mdu_rd != 0); e_a3 = bus.mdu_rd; e_wd = bus.mdu_wd; m_byp = 1;
      chk_wd = e_we;
    end
`endif
    check("mdu_ready", bus.mdu_ready, m_ready);
    check("stall", bus.stall, pend_m[bus.dec_rs1] | pend_m[bus.dec_rs2] | pend_m[bus.dec_rd]);
    check("rf_we", bus.rf_we, e_we);
    check("rf_a3", bus.rf_a3, e_a3);
    if (chk_wd) check("rf_wd", bus.rf_wd, e_wd);
    if (bus.rf_we) writes.push_back(int'(bus.rf_a3));
  endtask

  // Advance one clock and apply the spec rules to the model.
  task automatic clock_update();
    @(posedge clk);
    if (m_pop) begin
      pend_m[q[0].rd] = 1'b0;
      void'(q.pop_front());
    end
    if (m_byp) pend_m[bus.mdu_rd] = 1'b0;
    if (bus.mdu_valid && m_ready && !m_byp) q.push_back('{rd: bus.mdu_rd, wd: bus.mdu_wd});
    if (bus.iss_mdu) pend_m[bus.iss_rd] = 1'b1;
    pend_m[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    clock_update();
  endtask

  initial begin
    clear_inputs();
    q.delete(); pend_m = '0;
    // Power-on reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.mdu_ready, 1);
    check("rst_we", bus.rf_we, 0);
    check("rst_stall", bus.stall, 0);
    rst = 0;
    @(negedge clk);

    // Issue rd=7, then the result returns on an idle port.
    bus.iss_mdu = 1; bus.iss_rd = 7; bus.dec_rs2 = 7;
    step();
    bus.iss_mdu = 0;
    settle_check();
    check("p2_stall", bus.stall, 1);
    bus.mdu_valid = 1; bus.mdu_rd = 7; bus.mdu_wd = 32'h1234;
    settle_check();
    clock_update();
    bus.mdu_valid = 0;
    settle_check();
`ifndef RF_BYPASS_EN
    check("p2_we", bus.rf_we, 1);
    check("p2_a3", bus.rf_a3, 7);
    check("p2_wd", bus.rf_wd, 32'h1234);
    check("p2_stall_hold", bus.stall, 1);
`endif
    clock_update();
    settle_check();
    check("p2_stall_drop", bus.stall, 0);
    clock_update();
    bus.dec_rs2 = 0;

    // Six back-to-back pipeline writebacks while four MDU results queue up.
    for (int r = 3; r <= 6; r++) begin
      bus.iss_mdu = 1; bus.iss_rd = 5'(r); step();
    end
    bus.iss_mdu = 0;
    writes.delete();
    for (int i = 0; i < 6; i++) begin
      bus.wb_we = 1; bus.wb_rd = 5'(10 + i); bus.wb_wd = $urandom;
      bus.mdu_valid = (i < 4); bus.mdu_rd = 5'(3 + i); bus.mdu_wd = $urandom;
      step();
      if (i == 3) check("full_ready", bus.mdu_ready, 0);
    end
    bus.wb_we = 0; bus.mdu_valid = 0;
    for (int i = 0; i < 6; i++) check("busy_no_mdu_write", (writes[i] >= 3 && writes[i] <= 6), 0);
    writes.delete();
    repeat (5) step();
    check("drain_count", writes.size(), 4);
    for (int i = 0; i < 4 && i < writes.size(); i++) check("drain_order", writes[i], 3 + i);

    // Full FIFO with a pop and a new result in the same cycle.
    for (int i = 0; i < 4; i++) begin
      bus.wb_we = 1; bus.wb_rd = 1; bus.wb_wd = $urandom;
      bus.mdu_valid = 1; bus.mdu_rd = 5'(20 + i); bus.mdu_wd = $urandom;
      step();
    end
    bus.wb_we = 0; bus.mdu_rd = 24; bus.mdu_wd = 32'hCAFE;
    settle_check();
    check("full_pop_ready", bus.mdu_ready, 0);
    check("full_pop_a3", bus.rf_a3, 20);
    clock_update();
    // Writeback to x0 leaves the port free for the FIFO head.
    bus.wb_we = 1; bus.wb_rd = 0; bus.wb_wd = 32'hDEAD;
    settle_check();
    check("retry_ready", bus.mdu_ready, 1);
    check("x0_head_we", bus.rf_we, 1);
    check("x0_head_a3", bus.rf_a3, 21);
    clock_update();
    clear_inputs();
    repeat (5) step();
    check("retry_drained", q.size(), 0);

    // Re-issue rd=9 in the cycle the older rd=9 result drains.
    bus.iss_mdu = 1; bus.iss_rd = 9; step();
    bus.iss_mdu = 0;
    bus.wb_we = 1; bus.wb_rd = 1; bus.mdu_valid = 1; bus.mdu_rd = 9; bus.mdu_wd = 32'h99;
    step();
    bus.wb_we = 0; bus.mdu_valid = 0; bus.iss_mdu = 1; bus.iss_rd = 9;
    step();
    bus.iss_mdu = 0; bus.dec_rs1 = 9;
    settle_check();
    check("reissue_pend", bus.stall, 1);
    clock_update();
    bus.dec_rs1 = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.wb_we = ($urandom_range(0, 2) != 0);
      bus.wb_rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      bus.wb_wd = $urandom;
      bus.iss_mdu = ($urandom_range(0, 2) == 0); bus.iss_rd = 5'($urandom);
      bus.mdu_valid = ($urandom_range(0, 1) == 0);
      bus.mdu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.mdu_wd = $urandom;
      bus.dec_rs1 = 5'($urandom); bus.dec_rs2 = 5'($urandom); bus.dec_rd = 5'($urandom);
      step();
    end

    // Reset mid-operation with two buffered results and pend[5]=1.
    clear_inputs();
    repeat (6) step();
    bus.iss_mdu = 1; bus.iss_rd = 5; step();
    bus.iss_mdu = 0;
    for (int i = 0; i < 2; i++) begin
      bus.wb_we = 1; bus.wb_rd = 2; bus.mdu_valid = 1; bus.mdu_rd = 5'(11 + i); bus.mdu_wd = $urandom;
      step();
    end
    check("pre_rst_depth", q.size(), 2);
    clear_inputs();
    bus.dec_rs1 = 5;
    #2 rst = 1;
    #1;
    q.delete(); pend_m = '0;
    check("mid_rst_ready", bus.mdu_ready, 1);
    check("mid_rst_we", bus.rf_we, 0);
    check("mid_rst_stall", bus.stall, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
